// File: rtl/target_scheduler.sv
// Frame-rate target selector: scans 16 tracker regions per frame and issues one aim or home command.
// Optional feature: define TGT_SCHED_DEADBAND_EN to suppress re-commands that stay within DEADBAND of the lock.
module target_scheduler #(
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned DEADBAND    = 4,
  parameter int unsigned HOME_X      = 319,
  parameter int unsigned HOME_Y      = 239
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_upd,
  input  logic [15:0]      aim_detected_all,
  input  logic [15:0][9:0] aim_x_all,
  input  logic [15:0][9:0] aim_y_all,
  input  logic             tgt_ready,
  output logic             tgt_valid,
  output logic [9:0]       tgt_x,
  output logic [9:0]       tgt_y,
  output logic [3:0]       tgt_idx,
  output logic             tgt_home,
  output logic             locked,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned NREG = 16;
  localparam int unsigned XW   = 10;
  localparam int unsigned IW   = 4;
  localparam int unsigned DW   = 11;
  localparam int unsigned CW   = 8;
  localparam int unsigned LW   = $clog2(LOST_FRAMES + 1);

  localparam logic [XW-1:0] HX        = XW'(HOME_X);
  localparam logic [XW-1:0] HY        = XW'(HOME_Y);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_FRAMES - 1);
  localparam logic [LW-1:0] LOST_MAX  = LW'(LOST_FRAMES);
  localparam logic [CW-1:0] DROP_MAX  = '1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [IW-1:0] idx;
    logic          home;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_EMIT
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            scan_idx_q, scan_idx_d;
  logic [NREG-1:0]          det_q, det_d;
  logic [NREG-1:0][XW-1:0]  xs_q, xs_d;
  logic [NREG-1:0][XW-1:0]  ys_q, ys_d;
  logic                     best_found_q, best_found_d;
  logic [IW-1:0]            best_idx_q, best_idx_d;
  logic [DW-1:0]            best_dist_q, best_dist_d;
  logic [LW-1:0]            lost_q, lost_d;
  logic                     locked_q, locked_d;
  cmd_t                     cmd_q, cmd_d;
  logic                     valid_q, valid_d;
  logic [XW-1:0]            last_x_q, last_x_d;
  logic [XW-1:0]            last_y_q, last_y_d;
  logic [CW-1:0]            drop_q, drop_d;
  logic                     busy_q, busy_d;

  logic [XW-1:0]            ref_x_c, ref_y_c;
  logic [DW-1:0]            cur_dist_c;
  logic [XW-1:0]            pick_x_c, pick_y_c;
  logic                     hold_c;

  function automatic logic [XW-1:0] absdiff(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Distance of the region under scan from the lock point (or screen centre when unlocked).
  assign ref_x_c    = locked_q ? last_x_q : HX;
  assign ref_y_c    = locked_q ? last_y_q : HY;
  assign cur_dist_c = DW'(absdiff(xs_q[scan_idx_q], ref_x_c)) + DW'(absdiff(ys_q[scan_idx_q], ref_y_c));
  assign pick_x_c   = xs_q[best_idx_q];
  assign pick_y_c   = ys_q[best_idx_q];

`ifdef TGT_SCHED_DEADBAND_EN
  localparam logic [XW-1:0] DB = XW'(DEADBAND);
  assign hold_c = locked_q && (absdiff(pick_x_c, last_x_q) <= DB) && (absdiff(pick_y_c, last_y_q) <= DB);
`else
  logic db_unused;
  assign db_unused = |XW'(DEADBAND);
  assign hold_c    = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    det_d        = det_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    best_found_d = best_found_q;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;
    lost_d       = lost_q;
    locked_d     = locked_q;
    cmd_d        = cmd_q;
    valid_d      = valid_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    drop_d       = drop_q;

    if (frame_upd && (state_q != S_IDLE) && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (frame_upd) begin
          det_d        = aim_detected_all;
          xs_d         = aim_x_all;
          ys_d         = aim_y_all;
          scan_idx_d   = '0;
          best_found_d = 1'b0;
          best_idx_d   = '0;
          best_dist_d  = '1;
          state_d      = S_SCAN;
        end
      end

      S_SCAN: begin
        // Strict less-than keeps the lowest index on equal distances.
        if (det_q[scan_idx_q] && (!best_found_q || (cur_dist_c < best_dist_q))) begin
          best_found_d = 1'b1;
          best_idx_d   = scan_idx_q;
          best_dist_d  = cur_dist_c;
        end
        scan_idx_d = scan_idx_q + IW'(1);
        if (scan_idx_q == IW'(NREG - 1)) begin
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (best_found_q) begin
          lost_d   = '0;
          locked_d = 1'b1;
          if (hold_c) begin
            state_d = S_IDLE;
          end else begin
            cmd_d   = '{x: pick_x_c, y: pick_y_c, idx: best_idx_q, home: 1'b0};
            valid_d = 1'b1;
            state_d = S_EMIT;
          end
        end else if (lost_q < LOST_LAST) begin
          lost_d  = lost_q + LW'(1);
          state_d = S_IDLE;
        end else if (lost_q == LOST_LAST) begin
          lost_d   = LOST_MAX;
          locked_d = 1'b0;
          cmd_d    = '{x: HX, y: HY, idx: '0, home: 1'b1};
          valid_d  = 1'b1;
          state_d  = S_EMIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EMIT: begin
        if (tgt_ready) begin
          valid_d  = 1'b0;
          last_x_d = cmd_q.x;
          last_y_d = cmd_q.y;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      scan_idx_q   <= '0;
      det_q        <= '0;
      xs_q         <= '0;
      ys_q         <= '0;
      best_found_q <= 1'b0;
      best_idx_q   <= '0;
      best_dist_q  <= '1;
      lost_q       <= '0;
      locked_q     <= 1'b0;
      cmd_q        <= '{x: HX, y: HY, idx: '0, home: 1'b0};
      valid_q      <= 1'b0;
      last_x_q     <= HX;
      last_y_q     <= HY;
      drop_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      det_q        <= det_d;
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      best_found_q <= best_found_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
      lost_q       <= lost_d;
      locked_q     <= locked_d;
      cmd_q        <= cmd_d;
      valid_q      <= valid_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign tgt_valid = valid_q;
  assign tgt_x     = cmd_q.x;
  assign tgt_y     = cmd_q.y;
  assign tgt_idx   = cmd_q.idx;
  assign tgt_home  = cmd_q.home;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/target_scheduler.md
# target_scheduler

Frame-rate target selector placed between the red-blob tracker and the pan/tilt motor controller. After each tracker frame update it scans the 16 per-region detections sequentially and picks one aim point: nearest to the current lock, or nearest to screen centre when unlocked. It issues that point as a single valid/ready command, keeps the lock through short dropouts, and sends a home command after a sustained loss.

## Interface
- `LOST_FRAMES`, default 8: consecutive empty frames before a home command is issued.
- `DEADBAND`, default 4: per-axis suppression radius in pixels, used only with the macro.
- `HOME_X`, default 319: centre and home X.
- `HOME_Y`, default 239: centre and home Y.

Ports (clock and reset first):
- `clk` input 1: single system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `frame_upd` input 1: one-cycle pulse; tracker outputs are stable and updated this cycle.
- `aim_detected_all` input [15:0]: per-region detection flags.
- `aim_x_all` input [15:0][9:0]: per-region centre X.
- `aim_y_all` input [15:0][9:0]: per-region centre Y.
- `tgt_ready` input 1: motor controller accepts the command.
- `tgt_valid` output 1: command pending.
- `tgt_x` output 10: command X.
- `tgt_y` output 10: command Y.
- `tgt_idx` output 4: source region of the command; 0 for home.
- `tgt_home` output 1: payload is a home command.
- `locked` output 1: a target is currently locked.
- `busy` output 1: state is not IDLE.
- `drop_cnt` output 8: saturating count of dropped `frame_upd` pulses.

## Operation
- States: IDLE, SCAN, DECIDE, EMIT.
- **IDLE**
  - On `frame_upd`, snapshot all three input arrays into registers.
  - Set `scan_idx`=0 and go to SCAN.
- **SCAN**
  - One region per cycle, index 0 to 15.
  - Reference point = last commanded (x,y) if `locked`, else (`HOME_X`,`HOME_Y`).
  - Distance = |dx|+|dy|, computed unsigned in 11 bits.
  - A region replaces the running best only if strictly smaller, so ties go to the lowest index.
  - After index 15, go to DECIDE.
- **DECIDE, best found**
  - Clear `lost_cnt` and set `locked`=1.
  - Load the payload with `tgt_home`=0 and go to EMIT.
- **DECIDE, none found**
  - If `lost_cnt` < `LOST_FRAMES`-1: increment `lost_cnt` and go to IDLE with no command. The lock is kept.
  - If `lost_cnt` == `LOST_FRAMES`-1: set `lost_cnt`=`LOST_FRAMES`, clear `locked`, load the home payload (`HOME_X`, `HOME_Y`, idx 0, `tgt_home`=1) and go to EMIT.
  - If `lost_cnt` == `LOST_FRAMES`: no command; go to IDLE. The home command is issued once per loss.
- **EMIT**
  - `tgt_valid`=1 with the payload held stable.
  - Transfer happens at the edge where `tgt_valid`&&`tgt_ready`. `tgt_valid` drops on that edge and the state returns to IDLE.
- **Dropped frames**
  - A `frame_upd` arriving in any state other than IDLE is dropped; `drop_cnt` increments and saturates at 255.
  - This includes the EMIT handshake edge.
  - The snapshot and payload are unaffected.
- **Stored position**
  - The last commanded (x,y) updates only on transfer.
  - A home transfer sets it to (`HOME_X`,`HOME_Y`).

## Timing
- Reset values:
  - `tgt_valid`=0, `tgt_x`=`HOME_X`, `tgt_y`=`HOME_Y`, `tgt_idx`=0.
  - `tgt_home`=0, `locked`=0, `busy`=0, `drop_cnt`=0.
  - Internal: `lost_cnt`=0, state IDLE.
- `frame_upd` sampled at edge k gives SCAN at edges k+1..k+16 and DECIDE at k+17. `tgt_valid` is visible after edge k+17, a latency of 17 cycles.
- `busy` is high from k+1 until return to IDLE.
- All outputs are registered.
- `reset_n` low mid-operation aborts immediately to the reset values. A pending command is discarded without handshake.
- `tgt_ready` has no effect outside EMIT.

## Configuration
- `TGT_SCHED_DEADBAND_EN` defined:
  - In DECIDE with best found, if `locked` was already 1 and |x−last_x| ≤ `DEADBAND` and |y−last_y| ≤ `DEADBAND`, update the lock but emit nothing; go to IDLE.
  - The first acquisition and home commands are always emitted.
- Macro undefined: every found target is emitted.

## Test plan
- **Acquisition**
  - Stimulus: only region 5 at (200,100), unlocked; `tgt_ready` held low 5 cycles.
  - Required: `tgt_valid` after 17 cycles with x=200, y=100, idx=5; `locked`=1; payload stable until ready.
- **Centre preference**
  - Stimulus: unlocked; region 0 at (100,50) and region 10 at (330,250).
  - Required: idx=10 (distance 22 vs 408).
  - Equal-distance regions 3 and 12: idx=3.
- **Lock following**
  - Stimulus: locked at (330,250); next frame has region 6 at (319,239) and region 9 at (340,260).
  - Required: idx=9 (20 < 22).
- **Loss**
  - Stimulus: `LOST_FRAMES`=8, locked.
  - Required:
    - Empty frames 1–7: no `tgt_valid`.
    - Frame 8: home (319,239), `tgt_home`=1, `locked`=0.
    - Frame 9: nothing.
    - A detection then gives a normal command.
- **Drop**
  - Stimulus: second `frame_upd` 5 cycles after the first.
  - Required: `drop_cnt`=1, first command unchanged; 300 drops give `drop_cnt`=255.
- **Deadband**
  - Stimulus: locked at (200,100); then (203,98); then (205,100).
  - With macro: no command for (203,98), command for (205,100).
  - Without macro: both emitted.
